fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 3-stage RV32I pipeline. It owns the program counter and drives the address of the combinational instruction memory. It captures the returned instruction into the IF/ID pipeline register for decode/execute. It handles stall, branch/jump redirect with wrong-path flush, target misalignment, out-of-range fetch faults and a fetched-instruction counter.

Parameters:
REG_SIZE, 32, datapath/address width (XLEN)
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 256, number of 32-bit words in instruction memory; fetch range is [0, IMEM_WORDS*4)

Ports:
clk  input  1  pipeline clock
rst_n  input  1  reset; one clock; asynchronous assert, active-low
stall_i  input  1  hold PC and IF/ID (load-use or structural hazard)
br_taken_i  input  1  redirect request from execute (taken branch, JAL, JALR)
br_target_i  input  REG_SIZE  redirect target byte address
imem_addr_o  output  REG_SIZE  byte address to instruction memory (= pc_f)
imem_inst_i  input  REG_SIZE  instruction word returned same cycle
pc_d_o  output  REG_SIZE  IF/ID: PC of held instruction
pc4_d_o  output  REG_SIZE  IF/ID: PC+4 of held instruction (link value)
inst_d_o  output  REG_SIZE  IF/ID: instruction word
valid_d_o  output  1  IF/ID: instruction is real (not a bubble)
misalign_o  output  1  one-cycle pulse: redirect target had [1:0] != 0
fetch_fault_o  output  1  sticky: a fetch was attempted outside the memory range
fetch_cnt_o  output  32  count of valid instructions loaded into IF/ID

Behaviour:
- Reset (async, rst_n=0):
  - pc_f = RESET_PC.
  - pc_d_o = 0, pc4_d_o = 0.
  - inst_d_o = NOP (32'h0000_0013), valid_d_o = 0.
  - misalign_o = 0, fetch_fault_o = 0, fetch_cnt_o = 0.
- imem_addr_o = pc_f, combinationally. The memory is combinational, so imem_inst_i is valid in the same cycle and fetch latency is 0 cycles to IF/ID input, 1 cycle to IF/ID output.
- in_range = (pc_f[REG_SIZE-1:2] < IMEM_WORDS).
- Per-edge priority, highest first:
  1. br_taken_i=1 (wins over stall_i):
     - pc_f <= {br_target_i[REG_SIZE-1:2], 2'b00}.
     - IF/ID <= bubble: inst=NOP, valid=0, pc=0, pc4=0.
     - misalign_o <= |br_target_i[1:0].
  2. stall_i=1: pc_f, IF/ID and fetch_cnt_o hold; misalign_o <= 0.
  3. Normal, in_range=1:
     - pc_f <= pc_f + 4 (modulo 2^REG_SIZE; wraps to 0).
     - IF/ID <= {pc_f, pc_f+4, imem_inst_i, valid=1}.
     - fetch_cnt_o <= fetch_cnt_o + 1 (wraps).
  4. Normal, in_range=0:
     - pc_f holds.
     - IF/ID <= bubble.
     - fetch_fault_o <= 1; it stays set until reset, and a redirect does not clear it.
- misalign_o is 0 on every edge not covered by case 1 with a misaligned target.
- The fault check uses pc_f only; it is never evaluated on the redirect edge itself.
- rst_n asserted mid-operation restores all reset values immediately. The first edge after release fetches RESET_PC.
- No X propagation: imem_inst_i is not captured when in_range=0.

Decomposition:
- Shared package riscv_pkg:
  - XLEN = 32.
  - NOP_INST = 32'h0000_0013.
  - RESET_PC default.
  - packed struct if_id_t {pc, pc4, inst, valid}.
- One natural sub-module, if_id_reg: the IF/ID register with load/hold/bubble controls and async active-low reset to the bubble value.
- PC logic, fault/misalign flags and counter stay in fetch_stage.

Test Plan:
- Reset release, no stall, memory words 0..3 = A,B,C,D:
  - imem_addr_o steps 0,4,8,C.
  - IF/ID shows (0,A),(4,B),(8,C) one cycle behind, valid_d_o=1.
  - fetch_cnt_o = 3 after 3 edges.
- stall_i high 2 cycles while pc_f=8: pc_f stays 8, IF/ID holds (4,B), fetch_cnt_o unchanged, then resumes with (8,C).
- br_taken_i=1 with target 32'h40 while stall_i=1:
  - next cycle pc_f=40, valid_d_o=0, inst_d_o=NOP, misalign_o=0.
  - the following edge gives IF/ID (40, mem[16]).
- Target 32'h46: pc_f=44, misalign_o=1 for exactly one cycle.
- IMEM_WORDS=256 with pc reaching 32'h400:
  - fetch_fault_o=1 sticky, valid_d_o=0, pc_f holds 400.
  - a redirect to 0 resumes fetch while fetch_fault_o stays 1.
- Assert rst_n low asynchronously mid-stream at pc_f=20: all outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the 3-stage RV32I pipeline: datapath width,
// canonical NOP, reset PC and the IF/ID pipeline register layout.
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;

  // A bubble carries a NOP so decode never sees a stale or undefined word.
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.pc    = {XLEN{1'b0}};
    b.pc4   = {XLEN{1'b0}};
    b.inst  = NOP_INST;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load, otherwise hold.
// Resets asynchronously to the bubble value.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  // IF/ID storage with bubble/load/hold control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= if_id_bubble();
    end else if (bubble_i) begin
      q_q <= if_id_bubble();
    end else if (load_i) begin
      q_q <= d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational imem address,
// fills IF/ID and tracks redirect misalignment, out-of-range faults and fetch count.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                REG_SIZE   = XLEN,
  parameter logic [XLEN-1:0]   RESET_PC   = RESET_PC_DEFAULT,
  parameter int                IMEM_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                br_taken_i,
  input  logic [REG_SIZE-1:0] br_target_i,
  output logic [REG_SIZE-1:0] imem_addr_o,
  input  logic [REG_SIZE-1:0] imem_inst_i,
  output logic [REG_SIZE-1:0] pc_d_o,
  output logic [REG_SIZE-1:0] pc4_d_o,
  output logic [REG_SIZE-1:0] inst_d_o,
  output logic                valid_d_o,
  output logic                misalign_o,
  output logic                fetch_fault_o,
  output logic [31:0]         fetch_cnt_o
);

  localparam logic [REG_SIZE-3:0] IMEM_WORDS_W = (REG_SIZE-2)'(IMEM_WORDS);

  logic [REG_SIZE-1:0] pc_q, pc_d;
  logic                misalign_q, misalign_d;
  logic                fault_q, fault_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                in_range_s;
  logic                load_s, bubble_s;
  if_id_t              if_id_in_s, if_id_out_s;

  assign in_range_s = (pc_q[REG_SIZE-1:2] < IMEM_WORDS_W);

  // Next-state selection: redirect > stall > in-range fetch > fault
  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    load_s     = 1'b0;
    bubble_s   = 1'b0;
    if (br_taken_i) begin
      pc_d       = {br_target_i[REG_SIZE-1:2], 2'b00};
      bubble_s   = 1'b1;
      misalign_d = |br_target_i[1:0];
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (in_range_s) begin
      pc_d   = pc_q + REG_SIZE'(4);
      load_s = 1'b1;
      cnt_d  = cnt_q + 32'd1;
    end else begin
      bubble_s = 1'b1;
      fault_d  = 1'b1;
    end
  end

  // Out-of-range words are never captured, so an undriven memory cannot leak X
  always_comb begin
    if_id_in_s.pc    = pc_q;
    if_id_in_s.pc4   = pc_q + REG_SIZE'(4);
    if_id_in_s.valid = 1'b1;
    if (in_range_s) begin
      if_id_in_s.inst = imem_inst_i;
    end else begin
      if_id_in_s.inst = NOP_INST;
    end
  end

  // PC, flags and fetch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_s),
    .bubble_i (bubble_s),
    .d_i      (if_id_in_s),
    .q_o      (if_id_out_s)
  );

  assign imem_addr_o   = pc_q;
  assign pc_d_o        = if_id_out_s.pc;
  assign pc4_d_o       = if_id_out_s.pc4;
  assign inst_d_o      = if_id_out_s.inst;
  assign valid_d_o     = if_id_out_s.valid;
  assign misalign_o    = misalign_q;
  assign fetch_fault_o = fault_q;
  assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect/reset traffic, compared against a cycle-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          WORDS = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, br_taken_i;
  logic [31:0] br_target_i;
  logic [31:0] imem_addr_o, imem_inst_i;
  logic [31:0] pc_d_o, pc4_d_o, inst_d_o;
  logic        valid_d_o, misalign_o, fetch_fault_o;
  logic [31:0] fetch_cnt_o;

  logic [31:0] mem [WORDS];

  // reference model state
  logic [31:0] m_pc, m_dpc, m_dpc4, m_dinst, m_cnt;
  logic        m_valid, m_mis, m_fault;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_inst_i = (imem_addr_o < 32'(WORDS * 4)) ? mem[imem_addr_o[9:2]] : 32'hDEAD_BEEF;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .br_taken_i    (br_taken_i),
    .br_target_i   (br_target_i),
    .imem_addr_o   (imem_addr_o),
    .imem_inst_i   (imem_inst_i),
    .pc_d_o        (pc_d_o),
    .pc4_d_o       (pc4_d_o),
    .inst_d_o      (inst_d_o),
    .valid_d_o     (valid_d_o),
    .misalign_o    (misalign_o),
    .fetch_fault_o (fetch_fault_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_dpc = 32'h0; m_dpc4 = 32'h0; m_dinst = NOP;
    m_valid = 1'b0; m_mis = 1'b0; m_fault = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic check_all();
    check("imem_addr", imem_addr_o, m_pc);
    check("pc_d", pc_d_o, m_dpc);
    check("pc4_d", pc4_d_o, m_dpc4);
    check("inst_d", inst_d_o, m_dinst);
    check("valid_d", {31'd0, valid_d_o}, {31'd0, m_valid});
    check("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
    check("fetch_fault", {31'd0, fetch_fault_o}, {31'd0, m_fault});
    check("fetch_cnt", fetch_cnt_o, m_cnt);
  endtask

  // one clock edge with the given inputs; model advances by the fetch rules
  task automatic step(input logic st, input logic br, input logic [31:0] tgt);
    logic [31:0] npc;
    stall_i = st; br_taken_i = br; br_target_i = tgt;
    npc   = m_pc;
    m_mis = 1'b0;
    if (br) begin
      npc = tgt & 32'hFFFF_FFFC;
      m_dpc = 32'h0; m_dpc4 = 32'h0; m_dinst = NOP; m_valid = 1'b0;
      m_mis = (tgt % 4) != 0;
    end else if (st) begin
      npc = m_pc;
    end else if (m_pc / 4 < WORDS) begin
      m_dpc = m_pc; m_dpc4 = m_pc + 32'd4; m_dinst = mem[m_pc / 4]; m_valid = 1'b1;
      npc = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end else begin
      m_dpc = 32'h0; m_dpc4 = 32'h0; m_dinst = NOP; m_valid = 1'b0;
      m_fault = 1'b1;
    end
    @(posedge clk);
    m_pc = npc;
    #1;
    check_all();
  endtask

  // asynchronous reset pulse between clock edges
  task automatic mid_reset();
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002;
    mem[2] = 32'hCCCC_0003; mem[3] = 32'hDDDD_0004;
    rst_n = 1'b0; stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = 32'h0;
    model_reset();
    #12 check_all();
    rst_n = 1'b1;

    // sequential fetch, then stall at pc 8
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("pc_d_after_stall", pc_d_o, 32'h8);
    check("inst_after_stall", inst_d_o, 32'hCCCC_0003);
    // redirect wins over stall; then misaligned target
    step(1'b1, 1'b1, 32'h40);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h46);
    check("misalign_pulse", {31'd0, misalign_o}, 32'd1);
    step(1'b0, 1'b0, 32'h0);
    check("misalign_cleared", {31'd0, misalign_o}, 32'd0);
    // run off the end of memory, then redirect back to 0
    step(1'b0, 1'b1, 32'h3F8);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
    check("fault_pc_hold", imem_addr_o, 32'h400);
    step(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    check("fault_sticky", {31'd0, fetch_fault_o}, 32'd1);
    // async reset at pc 0x20
    step(1'b0, 1'b1, 32'h14);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    check("pc_before_reset", imem_addr_o, 32'h20);
    mid_reset();
    step(1'b0, 1'b0, 32'h0);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] tgt;
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) tgt = $urandom;
      else tgt = $urandom_range(0, 32'h40F);
      if ($urandom_range(0, 299) == 0) mid_reset();
      step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8, tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
